// File: rtl/ktne_timer_pkg.sv
// Shared types, segment constants and helpers for the KTNE countdown timer.
package ktne_timer_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        DEFUSED = 3'd3,
        BOOM    = 3'd4
    } state_t;

    // Active-low DE-board segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Tick period in clock cycles for a given strike count, never below 1.
    function automatic int unsigned period_for_strikes(input int unsigned clk_hz,
                                                       input logic [2:0]  strikes);
        int unsigned p;
        if (strikes == 3'd0)      p = clk_hz;
        else if (strikes == 3'd1) p = (clk_hz * 32'd3) / 32'd4;
        else                      p = clk_hz / 32'd2;
        if (p == 32'd0) p = 32'd1;
        return p;
    endfunction

    // Packs MM..M:SS into BCD digits, least significant digit in [3:0].
    function automatic logic [19:0] bcd_time(input int unsigned mins,
                                             input int unsigned secs);
        logic [19:0] r;
        r[3:0]   = 4'(secs % 32'd10);
        r[7:4]   = 4'(secs / 32'd10);
        r[11:8]  = 4'(mins % 32'd10);
        r[15:12] = 4'((mins / 32'd10) % 32'd10);
        r[19:16] = 4'((mins / 32'd100) % 32'd10);
        return r;
    endfunction

endpackage

// File: rtl/ktne_countdown_timer_seg7.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes blank the digit.
//   bcd_i : 4-bit BCD digit
//   seg_o : 7-bit active-low segments (combinational)
module seg7_decode
    import ktne_timer_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ktne_countdown_timer.sv
// KTNE bomb countdown timer: BCD M..M:SS countdown with start/pause, defuse
// freeze and strikes that shorten the tick period and finally detonate.
//   CLOCK_50 : clock            reset    : sync active-high reset
//   start    : begin/resume     pause    : hold countdown
//   defused  : freeze (win)     strike   : one wrong action
//   hex      : active-low segments, sec ones in [6:0], then tens, then minutes
//   sec_tick : pulse per decrement   strikes : saturating strike count
//   running / exploded / safe : registered state flags (RUN / BOOM / DEFUSED)
module ktne_countdown_timer
    import ktne_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned MIN_DIGITS  = 1,
    parameter int unsigned START_MIN   = 5,
    parameter int unsigned START_SEC   = 0,
    parameter int unsigned MAX_STRIKES = 3
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pause,
    input  logic                          defused,
    input  logic                          strike,
    output logic [(MIN_DIGITS+2)*7-1:0]   hex,
    output logic                          sec_tick,
    output logic [2:0]                    strikes,
    output logic                          running,
    output logic                          exploded,
    output logic                          safe
);

    localparam int unsigned NDIG = MIN_DIGITS + 2;
    localparam int unsigned PW   = $clog2(CLK_HZ + 1);
    localparam logic [19:0]        START_ALL = bcd_time(START_MIN, START_SEC);
    localparam logic [NDIG*4-1:0]  START_BCD = START_ALL[NDIG*4-1:0];
    localparam logic [2:0]         MAX_S     = 3'(MAX_STRIKES);

    state_t                      state_q, state_d;
    logic [NDIG-1:0][BCD_W-1:0]  digits_q, digits_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic [2:0]                  strikes_q, strikes_d;
    logic                        sec_tick_q, sec_tick_d;
    logic                        running_q, exploded_q, safe_q;

    logic [NDIG-1:0][BCD_W-1:0]  dec_c;
    logic [PW-1:0]               last_cnt_c;
    logic [2:0]                  strikes_inc_c;
    logic                        final_strike_c;
    logic                        borrow;
    logic                        boom;

    // Terminal prescaler count for the current strike-dependent period.
    assign last_cnt_c = PW'(period_for_strikes(CLK_HZ, strikes_q) - 32'd1);

    assign strikes_inc_c  = (strikes_q < MAX_S) ? strikes_q + 3'd1 : strikes_q;
    assign final_strike_c = (strikes_q != MAX_S) && (strikes_inc_c == MAX_S);

    // BCD decrement by one second; sec tens wraps to 5, all others to 9.
    always_comb begin
        dec_c  = digits_q;
        borrow = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (borrow) begin
                if (digits_q[i] == 4'd0) begin
                    dec_c[i] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    dec_c[i] = digits_q[i] - 4'd1;
                    borrow   = 1'b0;
                end
            end
        end
    end

    // Next-state logic; defused outranks strike, which outranks pause/start.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        presc_d    = presc_q;
        strikes_d  = strikes_q;
        sec_tick_d = 1'b0;
        boom       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (defused) begin
                    state_d = DEFUSED;
                end else begin
                    // >= so a period shortened mid-second ticks on the next cycle.
                    if (presc_q >= last_cnt_c) begin
                        presc_d    = '0;
                        sec_tick_d = 1'b1;
                        digits_d   = dec_c;
                        if (dec_c == '0) boom = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (strike) begin
                        strikes_d = strikes_inc_c;
                        if (final_strike_c) boom = 1'b1;
                    end
                    if (digits_q == '0) boom = 1'b1;
                    if (boom)       state_d = BOOM;
                    else if (pause) state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (defused) begin
                    state_d = DEFUSED;
                end else begin
                    if (strike) begin
                        strikes_d = strikes_inc_c;
                        if (final_strike_c) boom = 1'b1;
                    end
                    if (boom)       state_d = BOOM;
                    else if (start) state_d = RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and datapath registers; flags trail the state by one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            digits_q   <= START_BCD;
            presc_q    <= '0;
            strikes_q  <= '0;
            sec_tick_q <= 1'b0;
            running_q  <= 1'b0;
            exploded_q <= 1'b0;
            safe_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            presc_q    <= presc_d;
            strikes_q  <= strikes_d;
            sec_tick_q <= sec_tick_d;
            running_q  <= (state_q == RUN);
            exploded_q <= (state_q == BOOM);
            safe_q     <= (state_q == DEFUSED);
        end
    end

    assign sec_tick = sec_tick_q;
    assign strikes  = strikes_q;
    assign running  = running_q;
    assign exploded = exploded_q;
    assign safe     = safe_q;

    for (genvar g = 0; g < int'(NDIG); g++) begin : g_seg
        seg7_decode u_seg (
            .bcd_i (digits_q[g]),
            .seg_o (hex[g*7 +: 7])
        );
    end

endmodule

// File: tb/tb_ktne_countdown_timer.sv
// Directed bench for ktne_countdown_timer: a 0:03 instance and a 1:00 instance
// share all inputs; expected values go through a scoreboard queue.
module tb_ktne_countdown_timer;
    import ktne_timer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, pause, defused, strike;
    logic [20:0] hex1, hex2;
    logic        tick1, tick2, run1, run2, exp1, exp2, safe1, safe2;
    logic [2:0]  str1, str2;

    ktne_countdown_timer #(.CLK_HZ(8), .MIN_DIGITS(1), .START_MIN(0),
                           .START_SEC(3), .MAX_STRIKES(3)) u_dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .pause(pause),
        .defused(defused), .strike(strike), .hex(hex1), .sec_tick(tick1),
        .strikes(str1), .running(run1), .exploded(exp1), .safe(safe1));

    ktne_countdown_timer #(.CLK_HZ(8), .MIN_DIGITS(1), .START_MIN(1),
                           .START_SEC(0), .MAX_STRIKES(3)) u_dut_min (
        .CLOCK_50(clk), .reset(reset), .start(start), .pause(pause),
        .defused(defused), .strike(strike), .hex(hex2), .sec_tick(tick2),
        .strikes(str2), .running(run2), .exploded(exp2), .safe(safe2));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] disp(input logic [6:0] m, input logic [6:0] t,
                                         input logic [6:0] o);
        return {11'b0, m, t, o};
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the selected instance shows sec_tick, capped at 64.
    task automatic wait_tick(input bit which, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (((which ? tick2 : tick1) !== 1'b1) && n < 64);
    endtask

    task automatic quiet(input int n, input bit which, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if ((which ? tick2 : tick1) === 1'b1) ticks++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    initial begin
        int n, t;
        reset = 1'b1; start = 1'b0; pause = 1'b0; defused = 1'b0; strike = 1'b0;
        cycle();
        reset = 1'b0;

        // Reset state of both instances
        push("rst_hex", disp(SEG_0, SEG_0, SEG_3));     check(32'(hex1));
        push("rst_hex_min", disp(SEG_1, SEG_0, SEG_0)); check(32'(hex2));
        push("rst_flags", 32'd0); check({28'd0, tick1, run1, exp1, safe1});
        push("rst_strikes", 32'd0); check(32'(str1));

        // Free-running countdown 0:03 -> BOOM
        pulse_start();
        push("tick1_interval", 32'd8); wait_tick(1'b0, n); check(32'(n));
        push("tick1_hex", disp(SEG_0, SEG_0, SEG_2)); check(32'(hex1));
        push("minute_borrow_hex", disp(SEG_0, SEG_5, SEG_9)); check(32'(hex2));
        push("running", 32'd1); check(32'(run1));
        push("tick2_interval", 32'd8); wait_tick(1'b0, n); check(32'(n));
        push("tick2_hex", disp(SEG_0, SEG_0, SEG_1)); check(32'(hex1));
        push("tick3_interval", 32'd8); wait_tick(1'b0, n); check(32'(n));
        push("tick3_hex", disp(SEG_0, SEG_0, SEG_0)); check(32'(hex1));
        push("exploded_same_cycle", 32'd0); check(32'(exp1));
        cycle();
        push("exploded_next_cycle", 32'd1); check(32'(exp1));
        push("boom_ticks", 32'd0); quiet(20, 1'b0, t); check(32'(t));
        push("boom_hex_frozen", disp(SEG_0, SEG_0, SEG_0)); check(32'(hex1));

        // Strikes shorten the period, the third detonates (1:00 instance)
        do_reset();
        pulse_start();
        push("s0_interval", 32'd8); wait_tick(1'b1, n); check(32'(n));
        strike = 1'b1; cycle(); strike = 1'b0;
        push("s1_interval", 32'd6); wait_tick(1'b1, n); check(32'(n + 1));
        push("s1_count", 32'd1); check(32'(str2));
        push("s1_interval_again", 32'd6); wait_tick(1'b1, n); check(32'(n));
        strike = 1'b1; cycle(); strike = 1'b0;
        push("s2_interval", 32'd4); wait_tick(1'b1, n); check(32'(n + 1));
        push("s2_hex", disp(SEG_0, SEG_5, SEG_6)); check(32'(hex2));
        strike = 1'b1; cycle(); strike = 1'b0;
        push("s3_count", 32'd3); check(32'(str2));
        cycle();
        push("s3_exploded", 32'd1); check(32'(exp2));
        push("s3_running", 32'd0); check(32'(run2));
        push("s3_frozen_ticks", 32'd0); quiet(10, 1'b1, t); check(32'(t));
        push("s3_frozen_hex", disp(SEG_0, SEG_5, SEG_6)); check(32'(hex2));

        // Pause preserves the residual fraction of a second
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) cycle();
        pause = 1'b1; cycle(); pause = 1'b0;
        push("pause_ticks", 32'd0); quiet(20, 1'b0, t); check(32'(t));
        push("pause_running", 32'd0); check(32'(run1));
        push("pause_hex", disp(SEG_0, SEG_0, SEG_3)); check(32'(hex1));
        pulse_start();
        push("resume_interval", 32'd3); wait_tick(1'b0, n); check(32'(n));

        // defused outranks a simultaneous strike; DEFUSED is terminal
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) cycle();
        defused = 1'b1; strike = 1'b1; cycle(); defused = 1'b0; strike = 1'b0;
        push("def_strikes", 32'd0); check(32'(str1));
        cycle();
        push("def_safe", 32'd1); check(32'(safe1));
        pulse_start();
        strike = 1'b1; cycle(); strike = 1'b0;
        push("def_ticks", 32'd0); quiet(20, 1'b0, t); check(32'(t));
        push("def_after_strikes", 32'd0); check(32'(str1));
        push("def_hex", disp(SEG_0, SEG_0, SEG_3)); check(32'(hex1));
        push("def_flags", 32'd1); check({28'd0, tick1, run1, exp1, safe1});

        // defused on the final tick wins; display holds 0:01
        do_reset();
        pulse_start();
        wait_tick(1'b0, n);
        wait_tick(1'b0, n);
        for (int i = 0; i < 7; i++) cycle();
        defused = 1'b1; cycle(); defused = 1'b0;
        push("def_final_hex", disp(SEG_0, SEG_0, SEG_1)); check(32'(hex1));
        push("def_final_tick", 32'd0); check(32'(tick1));
        cycle();
        push("def_final_flags", 32'd1); check({28'd0, tick1, run1, exp1, safe1});

        // Reset mid-RUN clears prescaler, strikes and flags
        do_reset();
        pulse_start();
        strike = 1'b1; cycle(); strike = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        do_reset();
        push("mid_rst_hex", disp(SEG_0, SEG_0, SEG_3)); check(32'(hex1));
        push("mid_rst_strikes", 32'd0); check(32'(str1));
        push("mid_rst_flags", 32'd0); check({28'd0, tick1, run1, exp1, safe1});
        pulse_start();
        push("mid_rst_interval", 32'd8); wait_tick(1'b0, n); check(32'(n));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ktne_countdown_timer.md
Name: ktne_countdown_timer

Overview:
- Parametrised bomb countdown timer for the KTNE board: M..M:SS display, start/pause, defuse freeze, and a strike input that speeds up the tick rate and detonates on the final strike.
- Drives the seven-segment HEX digits directly and exports a per-second tick plus state flags to the module-check and game-control logic.
- Successor to the fixed 3-digit free-running timer; the top-level wrapper instantiates it on CLOCK_50.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; base prescaler period.
- MIN_DIGITS, 1, number of BCD minute digits (1..3).
- START_MIN, 5, initial minutes; must be < 10**MIN_DIGITS.
- START_SEC, 0, initial seconds; must be < 60.
- MAX_STRIKES, 3, strike count that triggers detonation (2..7).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or resumes countdown.
- pause  in  1  one-cycle pulse; holds countdown.
- defused  in  1  one-cycle pulse; all modules solved, freeze time.
- strike  in  1  one-cycle pulse; one wrong action.
- hex  out  (MIN_DIGITS+2)*7  active-low segments; [6:0] = sec ones, [13:7] = sec tens, upper fields = minute digits, least significant first.
- sec_tick  out  1  one-cycle pulse on each countdown decrement.
- strikes  out  3  current strike count, saturating.
- running  out  1  high in RUN.
- exploded  out  1  high in BOOM.
- safe  out  1  high in DEFUSED.

Behaviour:
- Reset, synchronous and active-high, priority over all inputs:
  - state IDLE, time = START_MIN:START_SEC (BCD), prescaler 0, strikes 0.
  - sec_tick, running, exploded and safe are all 0.
  - hex shows the start time on the next cycle.
- States and transitions:
  - IDLE: start goes to RUN.
  - RUN: pause goes to PAUSED. defused goes to DEFUSED. Time reaching 0:00 goes to BOOM. Strike count reaching MAX_STRIKES goes to BOOM.
  - PAUSED: start goes to RUN. defused goes to DEFUSED. The prescaler holds its value, so the residual fraction of a second is preserved.
  - DEFUSED and BOOM are terminal until reset; time and strikes freeze.
- Prescaler and tick period:
  - The prescaler counts CLOCK_50 cycles only in RUN.
  - Period P by strike count: 0 strikes gives CLK_HZ; 1 strike gives CLK_HZ*3/4; 2 or more gives CLK_HZ/2. Integer division, minimum 1.
  - When the prescaler reaches P-1 it wraps to 0, sec_tick pulses for 1 cycle and time decrements.
  - On a period change mid-second, if the prescaler is already >= the new P-1, tick on the next cycle.
- Decrement rules, all BCD:
  - Sec ones 0 wraps to 9 with a borrow into sec tens.
  - Sec tens 0 wraps to 5 with a borrow into the minutes.
  - Minute digits borrow BCD-wise.
  - The 0:01 to 0:00 tick enters BOOM in the same cycle; exploded rises 1 cycle later (registered).
- Strikes:
  - Accepted only in RUN and PAUSED; the count saturates at MAX_STRIKES.
  - The strike that makes strikes == MAX_STRIKES enters BOOM immediately, regardless of remaining time.
- Simultaneous events in one cycle, highest priority first: reset, then defused, then strike, then pause, then start.
  - defused together with the final tick: DEFUSED wins and the display keeps 0:01.
  - strike together with a tick: both apply.
- start while in RUN, or pause while in IDLE or PAUSED: ignored.
- Segment encoding is active-low DE-board style: 0 = 7'b1000000, 1 = 7'b1111001, and so on.
- hex is a combinational decode of the registered BCD digits.

Decomposition:
- Package ktne_timer_pkg:
  - state_t enum (IDLE, RUN, PAUSED, DEFUSED, BOOM).
  - SEG_* 7-bit active-low digit constants.
  - Function period_for_strikes(clk_hz, strikes).
- Sub-module seg7_decode (4-bit BCD to 7-bit active-low), instantiated MIN_DIGITS+2 times via generate.

Test Plan (CLK_HZ=8, START_MIN=0, START_SEC=3, MAX_STRIKES=3 unless noted):
- Reset then start -> sec_tick every 8 cycles. hex ones goes 3,2,1,0. BOOM entered on the 3rd tick. exploded=1 one cycle later. Time then frozen.
- START_MIN=1, START_SEC=0, start, 1 tick -> display 0:59 (hex = SEG_0, SEG_5, SEG_9). Borrow across the minute boundary correct.
- In RUN, strike 1 -> next tick interval 6 cycles. Strike 2 -> 4 cycles. Strike 3 -> BOOM immediately, strikes=3, exploded=1.
- Start, run 5 cycles, pause for 20 cycles, start -> tick arrives 3 cycles after resume. No sec_tick during pause.
- defused and strike in the same cycle during RUN -> DEFUSED, safe=1, strikes unchanged. Later start/strike have no effect.
- reset asserted mid-RUN with the prescaler at 5 -> next cycle IDLE, display 0:03, strikes 0, all flags 0.
